// File: rtl/traffic_light_fsm_pkg.sv
// Shared definitions for the main/side intersection controller.
//   state_e   : phase encoding, also driven out on the debug state port
//   Lamp*     : one-hot lamp encodings, {red, yellow, green}
//   lamps_t   : bundle of all lamp outputs for one phase
//   lamps_for : phase -> lamp pattern lookup
package traffic_light_fsm_pkg;

    typedef enum logic [2:0] {
        StMainGrn = 3'd0,
        StMainYel = 3'd1,
        StWalk    = 3'd2,
        StSideGrn = 3'd3,
        StSideExt = 3'd4,
        StSideYel = 3'd5
    } state_e;

    localparam logic [2:0] LampRed = 3'b100;
    localparam logic [2:0] LampYel = 3'b010;
    localparam logic [2:0] LampGrn = 3'b001;

    typedef struct packed {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
    } lamps_t;

    // At most one road is ever non-red; WALK holds both roads red.
    function automatic lamps_t lamps_for(state_e st);
        lamps_t l;
        case (st)
            StMainGrn: l = '{main: LampGrn, side: LampRed, walk: 1'b0};
            StMainYel: l = '{main: LampYel, side: LampRed, walk: 1'b0};
            StWalk:    l = '{main: LampRed, side: LampRed, walk: 1'b1};
            StSideGrn: l = '{main: LampRed, side: LampGrn, walk: 1'b0};
            StSideExt: l = '{main: LampRed, side: LampGrn, walk: 1'b0};
            StSideYel: l = '{main: LampRed, side: LampYel, walk: 1'b0};
            default:   l = '{main: LampRed, side: LampRed, walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_fsm_tick_gen.sv
// Timer prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
//   clk   in   system clock, rising edge
//   reset in   asynchronous active-low reset, clears the count
//   clr   in   synchronous clear, restarts the count at 0 (phase entry)
//   tick  out  high while the count sits at TICK_DIV-1
module traffic_light_fsm_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    assign tick = (count_q == CntW'(TICK_DIV - 1));

    always_comb begin
        count_d = count_q + CntW'(1);
        if (clr || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main/side intersection controller with a pedestrian phase.
// Each phase runs for T_x prescaled ticks; road requests (sensor) and the latched
// pedestrian request (pendingWalk) are only looked at when the phase expires.
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   sensor       in   side-street vehicle present
//   pendingWalk  in   latched pedestrian request
//   reset_by_fsm out  one-cycle pulse on WALK entry, clears the request latch
//   main_lamp    out  {red,yellow,green}, one-hot
//   side_lamp    out  {red,yellow,green}, one-hot
//   walk_lamp    out  pedestrian WALK indicator
//   state        out  current phase code
module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned T_BASE   = 6,
    parameter int unsigned T_EXT    = 3,
    parameter int unsigned T_YEL    = 2,
    parameter int unsigned T_WALK   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       pendingWalk,
    output logic       reset_by_fsm,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk_lamp,
    output logic [2:0] state
);

    localparam int unsigned TMaxBE = (T_BASE > T_EXT) ? T_BASE : T_EXT;
    localparam int unsigned TMaxYW = (T_YEL > T_WALK) ? T_YEL : T_WALK;
    localparam int unsigned TMax   = (TMaxBE > TMaxYW) ? TMaxBE : TMaxYW;
    localparam int unsigned TimerW = $clog2(TMax + 1);

    // Timer holds remaining full ticks after the current one.
    function automatic logic [TimerW-1:0] phase_load(state_e st);
        case (st)
            StMainGrn, StSideGrn: return TimerW'(T_BASE - 1);
            StMainYel, StSideYel: return TimerW'(T_YEL - 1);
            StWalk:               return TimerW'(T_WALK - 1);
            StSideExt:            return TimerW'(T_EXT - 1);
            default:              return TimerW'(T_BASE - 1);
        endcase
    endfunction

    state_e            state_q;
    state_e            state_d;
    logic [TimerW-1:0] timer_q;
    logic [TimerW-1:0] timer_d;
    logic              tick;
    logic              expiry;
    logic              enter;
    lamps_t            lamps_d;

    traffic_light_fsm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (enter),
        .tick  (tick)
    );

    assign expiry = tick && (timer_q == '0);

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        timer_d = timer_q;
        if (tick && (timer_q != '0)) begin
            timer_d = timer_q - TimerW'(1);
        end

        case (state_q)
            StMainGrn: begin
                // Staying put still restarts the phase so main green is re-timed.
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = (sensor || pendingWalk) ? StMainYel : StMainGrn;
                end
            end
            StMainYel: begin
                // Walk wins over a waiting side car; the car is served after WALK.
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = pendingWalk ? StWalk : StSideGrn;
                end
            end
            StWalk: begin
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = sensor ? StSideGrn : StMainGrn;
                end
            end
            StSideGrn: begin
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = sensor ? StSideExt : StSideYel;
                end
            end
            StSideExt: begin
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = StSideYel;
                end
            end
            StSideYel: begin
                if (expiry) begin
                    enter   = 1'b1;
                    state_d = StMainGrn;
                end
            end
            default: begin
                // Unused codes recover immediately without any yellow.
                enter   = 1'b1;
                state_d = StMainGrn;
            end
        endcase

        if (enter) begin
            timer_d = phase_load(state_d);
        end

        lamps_d = lamps_for(state_d);
    end

    // Outputs are registered from the next state so they change with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StMainGrn;
            timer_q      <= phase_load(StMainGrn);
            reset_by_fsm <= 1'b0;
            main_lamp    <= LampGrn;
            side_lamp    <= LampRed;
            walk_lamp    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            reset_by_fsm <= (state_d == StWalk) && (state_q != StWalk);
            main_lamp    <= lamps_d.main;
            side_lamp    <= lamps_d.side;
            walk_lamp    <= lamps_d.walk;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with short timing parameters.
// Cycle c is the value sampled just before posedge c, counting posedge 0 as the
// first edge after reset release.
module tb_traffic_light_fsm;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor;
    logic       pendingWalk;
    logic       reset_by_fsm;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       walk_lamp;
    logic [2:0] state;

    traffic_light_fsm #(
        .TICK_DIV (4),
        .T_BASE   (3),
        .T_EXT    (2),
        .T_YEL    (1),
        .T_WALK   (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sensor       (sensor),
        .pendingWalk  (pendingWalk),
        .reset_by_fsm (reset_by_fsm),
        .main_lamp    (main_lamp),
        .side_lamp    (side_lamp),
        .walk_lamp    (walk_lamp),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_total  = 0;
    int inv_errs = 0;
    int cur_cycle;

    typedef struct {
        int         scen;
        logic       s;
        logic       p;
        int         cyc;
        logic [2:0] st;
        logic [2:0] m;
        logic [2:0] sd;
        logic       w;
        logic       r;
    } vec_t;

    vec_t vecs[$];

    // Lamp safety invariants, checked on every cycle.
    always @(negedge clk) begin
        if ((main_lamp == G && side_lamp != R) || (side_lamp == G && main_lamp != R) ||
            (walk_lamp && !(main_lamp == R && side_lamp == R)) ||
            !$onehot(main_lamp) || !$onehot(side_lamp)) begin
            inv_errs++;
            $display("FAIL lamp invariant at %0t: main=%b side=%b walk=%b", $time, main_lamp,
                     side_lamp, walk_lamp);
        end
    end

    task automatic check(input string name, input int cyc, input logic [7:0] act,
                         input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [2:0] m,
                             input logic [2:0] sd, input logic w, input logic r);
        check({tag, " state"}, cur_cycle, {5'd0, state}, {5'd0, st});
        check({tag, " main_lamp"}, cur_cycle, {5'd0, main_lamp}, {5'd0, m});
        check({tag, " side_lamp"}, cur_cycle, {5'd0, side_lamp}, {5'd0, sd});
        check({tag, " walk_lamp"}, cur_cycle, {7'd0, walk_lamp}, {7'd0, w});
        check({tag, " reset_by_fsm"}, cur_cycle, {7'd0, reset_by_fsm}, {7'd0, r});
    endtask

    task automatic start(input logic s, input logic p);
        reset       = 1'b0;
        sensor      = s;
        pendingWalk = p;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b1;
        cur_cycle = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cur_cycle++;
    endtask

    task automatic run_to(input int c);
        while (cur_cycle < c) step();
    endtask

    initial begin
        int cur_scen;
        int bad;
        reset       = 1'b0;
        sensor      = 1'b0;
        pendingWalk = 1'b0;

        // Idle: main green forever.
        vecs.push_back('{1, 0, 0,  0, 3'd0, G, R, 0, 0});
        vecs.push_back('{1, 0, 0, 12, 3'd0, G, R, 0, 0});
        vecs.push_back('{1, 0, 0, 99, 3'd0, G, R, 0, 0});
        // Side car present from reset.
        vecs.push_back('{2, 1, 0, 11, 3'd0, G, R, 0, 0});
        vecs.push_back('{2, 1, 0, 12, 3'd1, Y, R, 0, 0});
        vecs.push_back('{2, 1, 0, 15, 3'd1, Y, R, 0, 0});
        vecs.push_back('{2, 1, 0, 16, 3'd3, R, G, 0, 0});
        vecs.push_back('{2, 1, 0, 27, 3'd3, R, G, 0, 0});
        vecs.push_back('{2, 1, 0, 28, 3'd4, R, G, 0, 0});
        vecs.push_back('{2, 1, 0, 35, 3'd4, R, G, 0, 0});
        vecs.push_back('{2, 1, 0, 36, 3'd5, R, Y, 0, 0});
        vecs.push_back('{2, 1, 0, 39, 3'd5, R, Y, 0, 0});
        vecs.push_back('{2, 1, 0, 40, 3'd0, G, R, 0, 0});
        vecs.push_back('{2, 1, 0, 52, 3'd1, Y, R, 0, 0});
        // Pedestrian request only.
        vecs.push_back('{3, 0, 1, 12, 3'd1, Y, R, 0, 0});
        vecs.push_back('{3, 0, 1, 15, 3'd1, Y, R, 0, 0});
        vecs.push_back('{3, 0, 1, 16, 3'd2, R, R, 1, 1});
        vecs.push_back('{3, 0, 1, 17, 3'd2, R, R, 1, 0});
        vecs.push_back('{3, 0, 1, 23, 3'd2, R, R, 1, 0});
        vecs.push_back('{3, 0, 1, 24, 3'd0, G, R, 0, 0});
        vecs.push_back('{3, 0, 1, 36, 3'd1, Y, R, 0, 0});
        // Car and pedestrian together: walk first, then side green.
        vecs.push_back('{4, 1, 1, 12, 3'd1, Y, R, 0, 0});
        vecs.push_back('{4, 1, 1, 16, 3'd2, R, R, 1, 1});
        vecs.push_back('{4, 1, 1, 23, 3'd2, R, R, 1, 0});
        vecs.push_back('{4, 1, 1, 24, 3'd3, R, G, 0, 0});
        vecs.push_back('{4, 1, 1, 36, 3'd4, R, G, 0, 0});

        cur_scen = -1;
        foreach (vecs[i]) begin
            if (vecs[i].scen != cur_scen) begin
                start(vecs[i].s, vecs[i].p);
                cur_scen = vecs[i].scen;
            end
            run_to(vecs[i].cyc);
            check_all($sformatf("scen%0d", vecs[i].scen), vecs[i].st, vecs[i].m, vecs[i].sd,
                      vecs[i].w, vecs[i].r);
        end

        // Idle for 100 cycles: never leaves main green, never pulses the clear.
        start(1'b0, 1'b0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            if (reset_by_fsm !== 1'b0 || state !== 3'd0 || main_lamp !== G) bad++;
            step();
        end
        check("idle bad cycles", cur_cycle, 8'(bad), 8'd0);

        // Reset during SIDE_EXT aborts the phase at once, timing restarts on release.
        start(1'b1, 1'b0);
        run_to(30);
        check_all("pre-reset", 3'd4, R, G, 0, 0);
        reset = 1'b0;
        #1;
        check_all("async reset", 3'd0, G, R, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("held reset", 3'd0, G, R, 0, 0);
        reset     = 1'b1;
        cur_cycle = 0;
        run_to(11);
        check_all("post-reset 11", 3'd0, G, R, 0, 0);
        run_to(12);
        check_all("post-reset 12", 3'd1, Y, R, 0, 0);

        // Inputs raised only between expiries are ignored.
        start(1'b0, 1'b0);
        run_to(3);
        sensor      = 1'b1;
        pendingWalk = 1'b1;
        run_to(9);
        sensor      = 1'b0;
        pendingWalk = 1'b0;
        run_to(12);
        check_all("ignored glitch 12", 3'd0, G, R, 0, 0);
        run_to(24);
        check_all("ignored glitch 24", 3'd0, G, R, 0, 0);

        // New request raised during WALK after the clear pulse is served next round.
        start(1'b0, 1'b1);
        run_to(16);
        check_all("rewalk first", 3'd2, R, R, 1, 1);
        run_to(17);
        pendingWalk = 1'b0;
        run_to(19);
        pendingWalk = 1'b1;
        run_to(24);
        check_all("rewalk main", 3'd0, G, R, 0, 0);
        run_to(35);
        check_all("rewalk main end", 3'd0, G, R, 0, 0);
        run_to(36);
        check_all("rewalk yellow", 3'd1, Y, R, 0, 0);
        run_to(40);
        check_all("rewalk second", 3'd2, R, R, 1, 1);
        run_to(41);
        check_all("rewalk pulse end", 3'd2, R, R, 1, 0);

        check("lamp invariant errors", cur_cycle, 8'(inv_errs), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
